// File: rtl/soc_addr_map_cfg_pkg.sv
// Shared types for the address-map configuration block:
// rule entry, cfg field selector and commit FSM state.
package soc_addr_map_cfg_pkg;

    localparam int PKG_AW = 64;
    localparam int PKG_IW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FLD_START = 2'd0,
        FLD_END   = 2'd1,
        FLD_IDX   = 2'd2,
        FLD_EN    = 2'd3
    } cfg_field_e;

    typedef struct packed {
        logic [PKG_AW-1:0] start_addr;
        logic [PKG_AW-1:0] end_addr;
        logic [PKG_IW-1:0] idx;
        logic              en;
    } rule_t;

    localparam rule_t RULE_CLR = '0;

endpackage

// File: rtl/soc_addr_map_cfg_match.sv
// Combinational priority decoder: lowest enabled slot whose
// inclusive [start, end] range covers the address wins.
module soc_addr_map_cfg_match
    import soc_addr_map_cfg_pkg::*;
#(
    parameter int AXI_AW      = 64,
    parameter int N_RULES     = 8,
    parameter int IDX_W       = 2,
    parameter int DEFAULT_IDX = 0
) (
    input  rule_t             i_rules [N_RULES],
    input  logic [AXI_AW-1:0] i_addr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_hit
);

    logic [PKG_AW-1:0] w_addr;

    assign w_addr = PKG_AW'(i_addr);

    // Scan high to low so the lowest matching slot is written last.
    always_comb begin
        o_idx = IDX_W'(DEFAULT_IDX);
        o_hit = 1'b0;
        for (int i = N_RULES - 1; i >= 0; i--) begin
            if (i_rules[i].en &&
                (i_rules[i].start_addr <= w_addr) &&
                (w_addr <= i_rules[i].end_addr)) begin
                o_idx = i_rules[i].idx[IDX_W-1:0];
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_addr_map_cfg.sv
// Shadow/active address map with drain-then-swap commit.
// Optional sticky config lock: SOC_ADDR_MAP_CFG_LOCK_EN.
module soc_addr_map_cfg
    import soc_addr_map_cfg_pkg::*;
#(
    parameter int  AXI_AW          = 64,
    parameter int  N_RULES         = 8,
    parameter int  N_MST_PORTS     = 4,
    parameter int  MAX_OUTSTANDING = 15,
    parameter int  DEFAULT_IDX     = 0,
    localparam int IDX_W  = $clog2(N_MST_PORTS),
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
    localparam int RULE_W = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [RULE_W-1:0] cfg_rule_i,
    input  logic [1:0]        cfg_field_i,
    input  logic [AXI_AW-1:0] cfg_data_i,
    input  logic              commit_i,
    output logic              commit_busy_o,
    input  logic              txn_start_i,
    input  logic              txn_end_i,
    output logic              txn_gate_o,
    output logic [CNT_W-1:0]  outstanding_o,
    input  logic              lookup_valid_i,
    output logic              lookup_ready_o,
    input  logic [AXI_AW-1:0] lookup_addr_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [IDX_W-1:0]  result_idx_o,
    output logic              result_hit_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    rule_t            r_shadow [N_RULES];
    rule_t            r_active [N_RULES];
    logic             r_res_valid;
    logic [IDX_W-1:0] r_res_idx;
    logic             r_res_hit;
    logic             w_lock;
    logic             w_idle;
    logic             w_cfg_we;
    logic             w_commit;
    logic             w_lu_acc;
    logic [IDX_W-1:0] w_m_idx;
    logic             w_m_hit;
    cfg_field_e       w_fld;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_fld    = cfg_field_e'(cfg_field_i);
    assign w_cfg_we = cfg_valid_i && w_idle && !w_lock &&
                      (32'(cfg_rule_i) < N_RULES);
    assign w_commit = commit_i && w_idle && !w_lock;

`ifdef SOC_ADDR_MAP_CFG_LOCK_EN
    logic r_lock;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_lock <= 1'b0;
        else if (w_cfg_we && (w_fld == FLD_EN) && cfg_data_i[1] &&
                 (cfg_rule_i == RULE_W'(N_RULES - 1)))
            r_lock <= 1'b1;
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_commit) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_cnt == '0) w_state_nxt = ST_SWAP;
            ST_SWAP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (txn_start_i && !txn_end_i) begin
            if (r_cnt != MAX_CNT) r_cnt <= r_cnt + 1'b1;
        end else if (txn_end_i && !txn_start_i) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_RULES; i++) r_shadow[i] <= RULE_CLR;
        end else if (w_cfg_we) begin
            unique case (w_fld)
                FLD_START: r_shadow[cfg_rule_i].start_addr <= PKG_AW'(cfg_data_i);
                FLD_END:   r_shadow[cfg_rule_i].end_addr   <= PKG_AW'(cfg_data_i);
                FLD_IDX:   r_shadow[cfg_rule_i].idx <= PKG_IW'(cfg_data_i[IDX_W-1:0]);
                FLD_EN:    r_shadow[cfg_rule_i].en  <= cfg_data_i[0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_RULES; i++) r_active[i] <= RULE_CLR;
        end else if (r_state == ST_SWAP) begin
            r_active <= r_shadow;
        end
    end

    soc_addr_map_cfg_match #(
        .AXI_AW      (AXI_AW),
        .N_RULES     (N_RULES),
        .IDX_W       (IDX_W),
        .DEFAULT_IDX (DEFAULT_IDX)
    ) u_match (
        .i_rules (r_active),
        .i_addr  (lookup_addr_i),
        .o_idx   (w_m_idx),
        .o_hit   (w_m_hit)
    );

    // No acceptance during SWAP, so every result sees a stable table.
    assign lookup_ready_o = (!r_res_valid || result_ready_i) &&
                            (r_state != ST_SWAP);
    assign w_lu_acc = lookup_valid_i && lookup_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= IDX_W'(DEFAULT_IDX);
            r_res_hit   <= 1'b0;
        end else if (w_lu_acc) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= w_m_idx;
            r_res_hit   <= w_m_hit;
        end else if (result_ready_i) begin
            r_res_valid <= 1'b0;
        end
    end

    assign cfg_ready_o    = w_idle;
    assign commit_busy_o  = !w_idle;
    assign txn_gate_o     = w_idle && (r_cnt < MAX_CNT);
    assign outstanding_o  = r_cnt;
    assign result_valid_o = r_res_valid;
    assign result_idx_o   = r_res_idx;
    assign result_hit_o   = r_res_hit;

endmodule

// File: tb/tb_soc_addr_map_cfg.sv
// Directed bench for soc_addr_map_cfg: decode, commit drain,
// counter saturation, result backpressure and reset abort.
module tb_soc_addr_map_cfg;

    localparam int AW   = 64;
    localparam int NR   = 8;
    localparam int NMP  = 8;
    localparam int MAXO = 15;
    localparam int DEF  = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [2:0]    cfg_rule_i = '0;
    logic [1:0]    cfg_field_i = '0;
    logic [AW-1:0] cfg_data_i = '0;
    logic          commit_i = 1'b0;
    logic          commit_busy_o;
    logic          txn_start_i = 1'b0;
    logic          txn_end_i = 1'b0;
    logic          txn_gate_o;
    logic [3:0]    outstanding_o;
    logic          lookup_valid_i = 1'b0;
    logic          lookup_ready_o;
    logic [AW-1:0] lookup_addr_i = '0;
    logic          result_valid_o;
    logic          result_ready_i = 1'b1;
    logic [2:0]    result_idx_o;
    logic          result_hit_o;

    int n_chk  = 0;
    int n_pass = 0;

    soc_addr_map_cfg #(
        .AXI_AW          (AW),
        .N_RULES         (NR),
        .N_MST_PORTS     (NMP),
        .MAX_OUTSTANDING (MAXO),
        .DEFAULT_IDX     (DEF)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_rule_i     (cfg_rule_i),
        .cfg_field_i    (cfg_field_i),
        .cfg_data_i     (cfg_data_i),
        .commit_i       (commit_i),
        .commit_busy_o  (commit_busy_o),
        .txn_start_i    (txn_start_i),
        .txn_end_i      (txn_end_i),
        .txn_gate_o     (txn_gate_o),
        .outstanding_o  (outstanding_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_ready_o (lookup_ready_o),
        .lookup_addr_i  (lookup_addr_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_idx_o   (result_idx_o),
        .result_hit_o   (result_hit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cfg_wr(input int rule, input int fld, input logic [63:0] d);
        cfg_rule_i  = 3'(rule);
        cfg_field_i = 2'(fld);
        cfg_data_i  = d;
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic set_rule(input int rule, input logic [63:0] s,
                            input logic [63:0] e, input int idx);
        cfg_wr(rule, 0, s);
        cfg_wr(rule, 1, e);
        cfg_wr(rule, 2, 64'(idx));
        cfg_wr(rule, 3, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (commit_busy_o && n < 10) begin
            tick();
            n++;
        end
        chk(tag, commit_busy_o, 1'b0);
    endtask

    task automatic commit(input string tag);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        wait_idle(tag);
    endtask

    task automatic lookup(input string tag, input logic [63:0] a,
                          input int idx, input logic hit);
        lookup_addr_i  = a;
        lookup_valid_i = 1'b1;
        result_ready_i = 1'b1;
        tick();
        lookup_valid_i = 1'b0;
        chk({tag, "_vld"}, result_valid_o, 1'b1);
        chk({tag, "_idx"}, result_idx_o, 64'(idx));
        chk({tag, "_hit"}, result_hit_o, hit);
    endtask

    task automatic txn(input logic s, input logic e, input int n);
        txn_start_i = s;
        txn_end_i   = e;
        for (int i = 0; i < n; i++) tick();
        txn_start_i = 1'b0;
        txn_end_i   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_cfg_ready", cfg_ready_o, 1'b1);
        chk("rst_busy", commit_busy_o, 1'b0);
        chk("rst_gate", txn_gate_o, 1'b1);
        chk("rst_outst", outstanding_o, 0);
        chk("rst_lu_ready", lookup_ready_o, 1'b1);
        chk("rst_res_vld", result_valid_o, 1'b0);
        chk("rst_res_idx", result_idx_o, DEF);
        chk("rst_res_hit", result_hit_o, 1'b0);

        // Basic decode; shadow write invisible before commit
        set_rule(0, 64'h1000, 64'h1FFF, 2);
        lookup("pre_commit", 64'h1800, DEF, 1'b0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("commit_busy", commit_busy_o, 1'b1);
        chk("commit_cfg_rdy", cfg_ready_o, 1'b0);
        wait_idle("commit0_idle");
        lookup("hit_1800", 64'h1800, 2, 1'b1);
        lookup("miss_2000", 64'h2000, DEF, 1'b0);
        lookup("lo_edge", 64'h1000, 2, 1'b1);
        lookup("hi_edge", 64'h1FFF, 2, 1'b1);
        lookup("below", 64'h0FFF, DEF, 1'b0);

        // Overlap priority
        set_rule(1, 64'h0, 64'hFFFF, 1);
        set_rule(3, 64'h100, 64'h1FF, 3);
        commit("commit1_idle");
        lookup("ovl_180", 64'h180, 1, 1'b1);
        lookup("ovl_1800", 64'h1800, 2, 1'b1);
        lookup("ovl_10000", 64'h10000, DEF, 1'b0);
        cfg_wr(1, 3, 64'd0);
        commit("commit2_idle");
        lookup("dis_180", 64'h180, 3, 1'b1);

        // Commit drains outstanding transactions first
        txn(1'b1, 1'b0, 3);
        chk("outst3", outstanding_o, 3);
        set_rule(2, 64'h20000, 64'h2FFFF, 4);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("drain_gate", txn_gate_o, 1'b0);
        chk("drain_busy", commit_busy_o, 1'b1);
        tick();
        tick();
        chk("drain_held", commit_busy_o, 1'b1);
        lookup("drain_old", 64'h20000, DEF, 1'b0);
        txn(1'b0, 1'b1, 3);
        chk("drain_cnt0", outstanding_o, 0);
        chk("drain_last", commit_busy_o, 1'b1);
        tick();
        chk("swap_busy", commit_busy_o, 1'b1);
        chk("swap_lu_rdy", lookup_ready_o, 1'b0);
        tick();
        chk("post_swap_idle", commit_busy_o, 1'b0);
        chk("post_swap_rdy", lookup_ready_o, 1'b1);
        lookup("new_tbl", 64'h20000, 4, 1'b1);

        // Counter saturation
        txn(1'b1, 1'b0, MAXO);
        chk("cnt_max", outstanding_o, MAXO);
        chk("gate_max", txn_gate_o, 1'b0);
        txn(1'b1, 1'b0, 1);
        chk("cnt_sat_hi", outstanding_o, MAXO);
        txn(1'b1, 1'b1, 1);
        chk("cnt_both_max", outstanding_o, MAXO);
        txn(1'b0, 1'b1, 1);
        chk("cnt_14", outstanding_o, MAXO - 1);
        chk("gate_14", txn_gate_o, 1'b1);
        txn(1'b1, 1'b1, 2);
        chk("cnt_both_14", outstanding_o, MAXO - 1);
        txn(1'b0, 1'b1, MAXO - 1);
        chk("cnt_zero", outstanding_o, 0);
        txn(1'b0, 1'b1, 1);
        chk("cnt_sat_lo", outstanding_o, 0);

        // Result held under backpressure
        lookup_addr_i  = 64'h1800;
        lookup_valid_i = 1'b1;
        result_ready_i = 1'b0;
        tick();
        lookup_addr_i = 64'h20000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_vld", result_valid_o, 1'b1);
            chk("bp_idx", result_idx_o, 2);
            chk("bp_hit", result_hit_o, 1'b1);
            chk("bp_lu_rdy", lookup_ready_o, 1'b0);
            tick();
        end
        result_ready_i = 1'b1;
        tick();
        lookup_valid_i = 1'b0;
        chk("bp_next_idx", result_idx_o, 4);
        tick();
        chk("bp_drained", result_valid_o, 1'b0);

        // Reset during DRAIN aborts the commit
        txn(1'b1, 1'b0, 1);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        tick();
        chk("abort_drain", commit_busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_idle", commit_busy_o, 1'b0);
        chk("abort_cnt", outstanding_o, 0);
        chk("abort_res_vld", result_valid_o, 1'b0);
        lookup("abort_act", 64'h1800, DEF, 1'b0);
        commit("abort_commit");
        lookup("abort_shd", 64'h1800, DEF, 1'b0);

`ifdef SOC_ADDR_MAP_CFG_LOCK_EN
        set_rule(0, 64'h1000, 64'h1FFF, 2);
        commit("lock_pre");
        lookup("lock_pre_lu", 64'h1800, 2, 1'b1);
        cfg_wr(NR - 1, 3, 64'd2);
        cfg_wr(0, 2, 64'd7);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        chk("lock_no_commit", commit_busy_o, 1'b0);
        chk("lock_cfg_rdy", cfg_ready_o, 1'b1);
        lookup("lock_tbl", 64'h1800, 2, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
